// File: rtl/tone_decoder.sv
// Square-wave tone decoder: measures the rising-edge period, matches it against an
// 8-entry note table and shows the locked note as an index and a 7-segment glyph.
module tone_decoder #(
  parameter logic [127:0] NOTE_PERIODS = {16'd1911, 16'd2025, 16'd2273, 16'd2551,
                                          16'd2863, 16'd3034, 16'd3405, 16'd3822},
  parameter int unsigned  TOL          = 32,
  parameter int unsigned  MATCH_N      = 2,
  parameter int unsigned  TIMEOUT      = 8191
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic [2:0]  note_idx,
  output logic        note_valid,
  output logic        note_strobe,
  output logic [15:0] period,
  output logic [7:0]  seg
);

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
  localparam logic [16:0] TolVal     = 17'(TOL);
  localparam logic [2:0]  MatchN     = 3'(MATCH_N);

  typedef enum logic [1:0] {StIdle, StArmed, StLocked} state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, dly_q;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_q, period_d;
  logic [2:0]  cand_q, cand_d;
  logic [2:0]  cmatch_q, cmatch_d;
  logic [2:0]  note_idx_q, note_idx_d;
  logic        strobe_q, strobe_d;

  logic        edge_det, meas, hit, match;
  logic [2:0]  hit_idx;
  logic [2:0]  cmatch_inc;

  assign edge_det = sync2_q & ~dly_q;
  // A period equal to TIMEOUT coincides with the timeout and is never measured.
  assign meas     = edge_det && (cnt_q != TimeoutVal);
  assign match    = meas && hit;

  // Lowest matching table index wins, so scan downward and let later hits override.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      logic [16:0] nom;
      logic [16:0] mea;
      logic [16:0] adiff;
      nom   = {1'b0, NOTE_PERIODS[16*i +: 16]};
      mea   = {1'b0, cnt_q};
      adiff = (mea >= nom) ? (mea - nom) : (nom - mea);
      if (adiff <= TolVal) begin
        hit     = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      dly_q      <= 1'b0;
      cnt_q      <= '0;
      period_q   <= '0;
      state_q    <= StIdle;
      cand_q     <= '0;
      cmatch_q   <= '0;
      note_idx_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      sync1_q    <= tone_in;
      sync2_q    <= sync1_q;
      dly_q      <= sync2_q;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cmatch_q   <= cmatch_d;
      note_idx_q <= note_idx_d;
      strobe_q   <= strobe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cmatch_d   = cmatch_q;
    note_idx_d = note_idx_q;
    strobe_d   = 1'b0;
    period_d   = period_q;
    cmatch_inc = (hit_idx == cand_q) ? (cmatch_q + 3'd1) : 3'd1;

    if (edge_det)                cnt_d = 16'd1;
    else if (cnt_q != TimeoutVal) cnt_d = cnt_q + 16'd1;
    else                         cnt_d = cnt_q;

    if (edge_det) begin
      unique case (state_q)
        StIdle: begin
          state_d  = StArmed;
          cmatch_d = '0;
        end
        StArmed, StLocked: begin
          if (meas) period_d = cnt_q;
          if (!match) begin
            state_d  = StArmed;
            cmatch_d = '0;
          end else if (state_q == StLocked && hit_idx == note_idx_q) begin
            cmatch_d = '0;
          end else begin
            cand_d = hit_idx;
            if (cmatch_inc == MatchN) begin
              state_d    = StLocked;
              note_idx_d = hit_idx;
              strobe_d   = 1'b1;
              cmatch_d   = '0;
            end else begin
              cmatch_d = cmatch_inc;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (cnt_q == TimeoutVal) begin
      state_d  = StIdle;
      cmatch_d = '0;
    end
  end

  always_comb begin
    note_idx    = note_idx_q;
    note_strobe = strobe_q;
    period      = period_q;
    note_valid  = (state_q == StLocked);
    seg         = 8'h40;
    if (note_valid) begin
      unique case (note_idx_q)
        3'd0: seg = 8'h39;
        3'd1: seg = 8'h5E;
        3'd2: seg = 8'h79;
        3'd3: seg = 8'h71;
        3'd4: seg = 8'h3D;
        3'd5: seg = 8'h77;
        3'd6: seg = 8'h7C;
        3'd7: seg = 8'hB9;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: a period-level note model feeds a strobe scoreboard,
// and directed checks compare the outputs after each tone burst.
`timescale 1ns/1ps
module tb_tone_decoder;

  localparam int Tol     = 32;
  localparam int MatchN  = 2;
  localparam int Timeout = 8191;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tone_in;
  logic [2:0]  note_idx;
  logic        note_valid;
  logic        note_strobe;
  logic [15:0] period;
  logic [7:0]  seg;

  tone_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .note_idx    (note_idx),
    .note_valid  (note_valid),
    .note_strobe (note_strobe),
    .period      (period),
    .seg         (seg)
  );

  always #500 clk = ~clk;

  int note_tbl [8] = '{3822, 3405, 3034, 2863, 2551, 2273, 2025, 1911};
  int seg_tbl  [8] = '{8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h77, 8'h7C, 8'hB9};

  int     n_checks = 0;
  int     n_errors = 0;
  int     exp_q [$];
  longint cyc = 0;
  longint last_rise = -1;

  // Model state: 0 idle, 1 armed, 2 locked.
  int m_state = 0;
  int m_idx   = 0;
  int m_cand  = 0;
  int m_cnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [2:0] idx,
                            input logic [7:0] sg, input logic [15:0] per);
    check({tag, "_valid"}, 32'(note_valid), 32'(v));
    if (v) check({tag, "_idx"}, 32'(note_idx), 32'(idx));
    check({tag, "_seg"}, 32'(seg), 32'(sg));
    check({tag, "_period"}, 32'(period), 32'(per));
  endtask

  task automatic model_edge(input longint gap);
    int hit_i;
    if (gap < 0 || gap >= Timeout || m_state == 0) begin
      m_state = 1;
      m_cnt   = 0;
      return;
    end
    hit_i = -1;
    for (int i = 0; i < 8; i++) begin
      int d;
      d = int'(gap) - note_tbl[i];
      if (d < 0) d = -d;
      if (hit_i < 0 && d <= Tol) hit_i = i;
    end
    if (hit_i < 0) begin
      m_state = 1;
      m_cnt   = 0;
    end else if (m_state == 2 && hit_i == m_idx) begin
      m_cnt = 0;
    end else begin
      if (hit_i == m_cand) m_cnt++;
      else begin
        m_cand = hit_i;
        m_cnt  = 1;
      end
      if (m_cnt == MatchN) begin
        m_state = 2;
        m_idx   = hit_i;
        m_cnt   = 0;
        exp_q.push_back(hit_i);
      end
    end
  endtask

  // n rising edges spaced p cycles; each edge is pushed through the model.
  task automatic drive(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      tone_in = 1'b1;
      model_edge((last_rise < 0) ? -1 : (cyc - last_rise));
      last_rise = cyc;
      repeat (p / 2) @(negedge clk);
      tone_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
    end
  endtask

  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (note_strobe) begin
        check("strobe_width", 32'(prev_strobe), 32'd0);
        check("strobe_valid", 32'(note_valid), 32'd1);
        if (exp_q.size() == 0) begin
          check("strobe_unexpected", 32'd1, 32'd0);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("strobe_idx", 32'(note_idx), 32'(e));
          check("strobe_seg", 32'(seg), 32'(seg_tbl[e]));
        end
      end
      prev_strobe <= note_strobe;
    end else begin
      prev_strobe <= 1'b0;
    end
  end

  initial begin
    #(64'd150_000_000);
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("reset", 1'b0, 3'd0, 8'h40, 16'd0);
    check("reset_idx", 32'(note_idx), 32'd0);
    check("reset_strobe", 32'(note_strobe), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    drive(2273, 3);
    expect_out("lock_a4", 1'b1, 3'd5, 8'h77, 16'd2273);
    drive(2300, 2);
    expect_out("hold_2300", 1'b1, 3'd5, 8'h77, 16'd2300);
    drive(2306, 2);
    expect_out("drop_2306", 1'b0, 3'd0, 8'h40, 16'd2306);

    drive(2241, 3);
    expect_out("lock_2241", 1'b1, 3'd5, 8'h77, 16'd2241);
    drive(2025, 1);
    expect_out("sw_hold0", 1'b1, 3'd5, 8'h77, 16'd2241);
    drive(2025, 1);
    expect_out("sw_hold1", 1'b1, 3'd5, 8'h77, 16'd2025);
    drive(2025, 1);
    expect_out("sw_b4", 1'b1, 3'd6, 8'h7C, 16'd2025);

    while (cyc < last_rise + 8193) @(negedge clk);
    check("timeout_pre", 32'(note_valid), 32'd1);
    @(negedge clk);
    expect_out("timeout", 1'b0, 3'd0, 8'h40, 16'd2025);
    drive(2273, 2);
    check("rearm_valid", 32'(note_valid), 32'd0);
    drive(2273, 1);
    expect_out("relock", 1'b1, 3'd5, 8'h77, 16'd2273);

    drive(1911, 3);
    expect_out("c5", 1'b1, 3'd7, 8'hB9, 16'd1911);
    drive(3822, 3);
    expect_out("c4", 1'b1, 3'd0, 8'h39, 16'd3822);
    drive(3000, 3);
    expect_out("p3000", 1'b0, 3'd0, 8'h40, 16'd3000);

    drive(2273, 3);
    check("pre_rst_valid", 32'(note_valid), 32'd1);
    repeat (500) @(negedge clk);
    @(posedge clk);
    #200 rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 3'd0, 8'h40, 16'd0);
    check("async_rst_idx", 32'(note_idx), 32'd0);
    m_state   = 0;
    m_idx     = 0;
    m_cand    = 0;
    m_cnt     = 0;
    last_rise = -1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    drive(2273, 2);
    check("post_rst_2edges", 32'(note_valid), 32'd0);
    drive(2273, 1);
    expect_out("post_rst_lock", 1'b1, 3'd5, 8'h77, 16'd2273);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
